// File: rtl/minirv_pkg.sv
// minirv shared definitions: datapath width,
// load funct3 encodings and write-back FSM states.
package minirv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } lsu_wb_state_t;

endpackage

// File: rtl/lsu_wb_load_align.sv
// Byte/halfword lane select with sign or zero extension,
// plus width/alignment legality for a load funct3.
module load_align #(
  parameter int XLEN = minirv_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] value,
  output logic            illegal
);
  import minirv_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{off, 3'b000} +: 8];
  assign h = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    value   = '0;
    illegal = 1'b0;
    unique case (funct3)
      F3_LB:  value = {{(XLEN-8){b[7]}}, b};
      F3_LBU: value = {{(XLEN-8){1'b0}}, b};
      F3_LH: begin
        value   = {{(XLEN-16){h[15]}}, h};
        illegal = off[0];
      end
      F3_LHU: begin
        value   = {{(XLEN-16){1'b0}}, h};
        illegal = off[0];
      end
      F3_LW: begin
        value   = word;
        illegal = |off;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// minirv write-back stage: load memory read, alignment,
// timeout/error reporting and register file write port.
module lsu_wb #(
  parameter int XLEN        = minirv_pkg::XLEN,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_wb_en,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_alu,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            wb_done,
  output logic            load_err
);
  import minirv_pkg::*;

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  lsu_wb_state_t   state;
  logic [15:0]     cnt;
  logic [4:0]      rd_q;
  logic            wb_en_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wd_q;

  logic [2:0]      sel_f3;
  logic [1:0]      sel_off;
  logic [XLEN-1:0] value;
  logic            illegal;

  // Legality is judged on the incoming op, alignment on the latched one.
  assign sel_f3  = (state == S_IDLE) ? in_funct3    : f3_q;
  assign sel_off = (state == S_IDLE) ? in_addr[1:0] : off_q;

  load_align #(.XLEN(XLEN)) u_align (
    .word    (mem_resp_data),
    .funct3  (sel_f3),
    .off     (sel_off),
    .value   (value),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            rd_q    <= in_rd;
            wb_en_q <= in_wb_en;
            if (!in_is_load) begin
              wd_q  <= in_alu;
              state <= S_WRITE;
            end else if (illegal) begin
              state <= S_ERR;
            end else begin
              f3_q   <= in_funct3;
              off_q  <= in_addr[1:0];
              addr_q <= {in_addr[XLEN-1:2], 2'b00};
              state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            wd_q  <= value;
            state <= S_WRITE;
          end else if (cnt == TO_LAST) begin
            state <= S_ERR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WRITE: state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = rst_n && (state == S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = addr_q;
  assign rf_we         = (state == S_WRITE) && wb_en_q && (rd_q != 5'd0);
  assign rf_rd         = rd_q;
  assign rf_wd         = wd_q;
  assign wb_done       = (state == S_WRITE) || (state == S_ERR);
  assign load_err      = (state == S_ERR);

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb with a retire scoreboard;
// a second instance uses a short memory timeout.
module tb_lsu_wb;
  import minirv_pkg::*;

  typedef struct {
    logic        we;
    logic        err;
    logic [4:0]  rd;
    logic [31:0] wd;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wb_en = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_alu = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  logic        in_ready, mem_req_valid, rf_we, wb_done, load_err;
  logic [31:0] mem_req_addr, rf_wd;
  logic [4:0]  rf_rd;

  logic        t_in_valid = 1'b0;
  logic        t_req_ready = 1'b0;
  logic        t_resp_valid = 1'b0;
  logic        t_in_ready, t_req_valid, t_rf_we, t_wb_done, t_load_err;
  logic [31:0] t_req_addr, t_rf_wd;
  logic [4:0]  t_rf_rd;

  always #5 clk = ~clk;

  lsu_wb #(.XLEN(32), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_alu(in_alu),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .wb_done(wb_done), .load_err(load_err)
  );

  lsu_wb #(.XLEN(32), .MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_alu(in_alu),
    .mem_req_valid(t_req_valid), .mem_req_ready(t_req_ready),
    .mem_req_addr(t_req_addr),
    .mem_resp_valid(t_resp_valid), .mem_resp_data(mem_resp_data),
    .rf_we(t_rf_we), .rf_rd(t_rf_rd), .rf_wd(t_rf_wd),
    .wb_done(t_wb_done), .load_err(t_load_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic retire(string tag, int bound);
    sb_t e;
    int k = 0;
    while (wb_done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " wb_done"}, 32'(wb_done), 32'd1);
    if (wb_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, " sb_entry"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, " rf_we"}, 32'(rf_we), 32'(e.we));
        chk({tag, " load_err"}, 32'(load_err), 32'(e.err));
        if (e.we) begin
          chk({tag, " rf_rd"}, 32'(rf_rd), 32'(e.rd));
          chk({tag, " rf_wd"}, rf_wd, e.wd);
        end
      end
    end
  endtask

  task automatic push(logic we, logic err, logic [4:0] rd,
                      logic [31:0] wd);
    sb_t e;
    e.we = we; e.err = err; e.rd = rd; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic alu_op(string tag, logic [4:0] rd, logic wb_en,
                        logic [31:0] alu, logic exp_we);
    in_valid = 1'b1; in_is_load = 1'b0;
    in_rd = rd; in_wb_en = wb_en; in_alu = alu;
    push(exp_we, 1'b0, rd, alu);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    retire(tag, 0);
    @(negedge clk);
    chk({tag, " idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic bad_load(string tag, logic [2:0] f3, logic [31:0] addr);
    in_valid = 1'b1; in_is_load = 1'b1; in_wb_en = 1'b1;
    in_rd = 5'd4; in_funct3 = f3; in_addr = addr;
    push(1'b0, 1'b1, 5'd4, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " no_req"}, 32'(mem_req_valid), 32'd0);
    retire(tag, 0);
    @(negedge clk);
    chk({tag, " err_pulse"}, 32'(load_err), 32'd0);
  endtask

  task automatic load(string tag, logic [4:0] rd, logic [2:0] f3,
                      logic [31:0] addr, logic [31:0] word,
                      logic [31:0] exp, int rdy_wait, int resp_wait);
    in_valid = 1'b1; in_is_load = 1'b1; in_wb_en = 1'b1;
    in_rd = rd; in_funct3 = f3; in_addr = addr;
    push(1'b1, 1'b0, rd, exp);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, " req_addr"}, mem_req_addr, {addr[31:2], 2'b00});
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      chk({tag, " req_hold"}, 32'(mem_req_valid), 32'd1);
      chk({tag, " addr_hold"}, mem_req_addr, {addr[31:2], 2'b00});
      chk({tag, " busy_req"}, 32'(in_ready), 32'd0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({tag, " req_drop"}, 32'(mem_req_valid), 32'd0);
    for (int i = 1; i < resp_wait; i++) begin
      chk({tag, " busy_wait"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    mem_resp_valid = 1'b1; mem_resp_data = word;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk({tag, " busy_wr"}, 32'(in_ready), 32'd0);
    retire(tag, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #2;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst wb_done", 32'(wb_done), 32'd0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst rf_wd", rf_wd, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    alu_op("alu rd5", 5'd5, 1'b1, 32'hDEADBEEF, 1'b1);
    alu_op("alu rd0", 5'd0, 1'b1, 32'h11112222, 1'b0);
    alu_op("alu noen", 5'd3, 1'b0, 32'h33334444, 1'b0);

    load("lb", 5'd10, F3_LB, 32'h0000_1003, 32'h80FF7F01,
         32'hFFFFFF80, 0, 1);
    load("lbu", 5'd11, F3_LBU, 32'h0000_1001, 32'h80FF7F01,
         32'h0000007F, 0, 1);
    load("lh", 5'd12, F3_LH, 32'h0000_1002, 32'h80FF7F01,
         32'hFFFF80FF, 0, 1);
    load("lw", 5'd13, F3_LW, 32'h0000_1000, 32'h80FF7F01,
         32'h80FF7F01, 0, 1);
    load("lhu", 5'd14, F3_LHU, 32'h0000_1000, 32'h80FF7F01,
         32'h00007F01, 0, 1);

    bad_load("mis lw", F3_LW, 32'h0000_1002);
    bad_load("mis lh", F3_LH, 32'h0000_1001);
    bad_load("f3 011", 3'b011, 32'h0000_1000);

    load("bp", 5'd15, F3_LB, 32'hABCD_0122, 32'h12345678,
         32'h00000034, 3, 5);

    // Timeout instance: no response, then a late one.
    in_is_load = 1'b1; in_wb_en = 1'b1; in_rd = 5'd6;
    in_funct3 = F3_LW; in_addr = 32'h0000_2000;
    t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    chk("to req_valid", 32'(t_req_valid), 32'd1);
    t_req_ready = 1'b1;
    @(negedge clk);
    t_req_ready = 1'b0;
    k = 0;
    while (t_load_err !== 1'b1 && k < 10) begin
      chk("to no_wb", 32'(t_wb_done), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("to load_err", 32'(t_load_err), 32'd1);
    chk("to latency", k, 32'd4);
    chk("to wb_done", 32'(t_wb_done), 32'd1);
    chk("to rf_we", 32'(t_rf_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    t_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
    @(negedge clk);
    t_resp_valid = 1'b0;
    chk("late wb_done", 32'(t_wb_done), 32'd0);
    chk("late rf_we", 32'(t_rf_we), 32'd0);
    chk("late in_ready", 32'(t_in_ready), 32'd1);
    in_is_load = 1'b0; in_rd = 5'd7; in_alu = 32'h12345678;
    t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    chk("to alu wb_done", 32'(t_wb_done), 32'd1);
    chk("to alu rf_we", 32'(t_rf_we), 32'd1);
    chk("to alu rf_rd", 32'(t_rf_rd), 32'd7);
    chk("to alu rf_wd", t_rf_wd, 32'h12345678);
    @(negedge clk);

    // Reset while waiting for a response.
    in_valid = 1'b1; in_is_load = 1'b1; in_wb_en = 1'b1;
    in_rd = 5'd9; in_funct3 = F3_LW; in_addr = 32'h0000_3000;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mid busy", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    chk("mid rst req_valid", 32'(mem_req_valid), 32'd0);
    chk("mid rst req_addr", mem_req_addr, 32'd0);
    chk("mid rst rf_rd", 32'(rf_rd), 32'd0);
    chk("mid rst rf_wd", rf_wd, 32'd0);
    chk("mid rst wb_done", 32'(wb_done), 32'd0);
    chk("mid rst load_err", 32'(load_err), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55AA55AA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stale wb_done", 32'(wb_done), 32'd0);
    chk("stale rf_we", 32'(rf_we), 32'd0);
    chk("stale in_ready", 32'(in_ready), 32'd1);

    alu_op("alu final", 5'd31, 1'b1, 32'h0BADF00D, 1'b1);
    chk("sb empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
